packet_injector: RTL

PACKET_INJECTOR -- requirements
Module: packet_injector

---
 rtl/noc_pkg.sv | 35 +++
 rtl/key_edge.sv | 38 +++
 rtl/packet_injector.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet injector: FSM states, the
// seven-segment glyph table and a width helper.
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Active-low segments, bit order {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_ZERO = 7'b0000001;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Glyph for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

  // Bits needed to index n items, never less than 1.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchroniser for a raw push-button plus a rising-edge pulse,
// so one press produces exactly one single-cycle action.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the raw key through the synchroniser and keep last synced value.
  always_comb begin
    meta_d = key_raw;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and edge-history flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/packet_injector.sv
// Operator-driven packet injector: push-buttons edit a payload and a target
// router, and a send key injects {1'b1, payload} towards that router.
//
// Handshake: a packet transfers on a rising clk edge where
// out_valid[pkt_dst] and out_ready[pkt_dst] are both 1. Once a valid bit is
// raised, it and out_data stay unchanged until that edge; at most one valid
// bit is ever high, and out_data is 0 whenever no valid bit is high.
module packet_injector
  import noc_pkg::*;
#(
  parameter int NUM_ROUTERS = 121,
  parameter int DATA_W      = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_on,
  input  logic                   sw_mode,
  input  logic                   sw_sel_data,
  input  logic                   sw_sel_router,
  input  logic                   key_inc,
  input  logic                   key_dec,
  input  logic                   key_send,
  output logic [NUM_ROUTERS-1:0] out_valid,
  input  logic [NUM_ROUTERS-1:0] out_ready,
  output logic [DATA_W:0]        out_data,
  output logic [15:0]            pkt_count,
  output logic [6:0]             hex_data,
  output logic [6:0]             hex_router,
  output state_e                 dbg_state
);

  localparam int IDX_W = clog2_min1(NUM_ROUTERS);
  localparam logic [IDX_W-1:0] ROUTER_MAX = IDX_W'(NUM_ROUTERS - 1);

  logic inc_rise, dec_rise, send_rise, send_level;
  logic unused_inc_level, unused_dec_level;

  key_edge u_key_inc (
    .clk(clk), .rst_n(rst_n), .key_raw(key_inc),
    .level(unused_inc_level), .rise(inc_rise)
  );

  key_edge u_key_dec (
    .clk(clk), .rst_n(rst_n), .key_raw(key_dec),
    .level(unused_dec_level), .rise(dec_rise)
  );

  key_edge u_key_send (
    .clk(clk), .rst_n(rst_n), .key_raw(key_send),
    .level(send_level), .rise(send_rise)
  );

  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  router_q, router_d;
  logic [6:0]        hex_data_q, hex_data_d;
  logic [6:0]        hex_router_q, hex_router_d;

  logic              edit_data, edit_router, one_key;

  // Payload/router editing; conflicting selects or keys leave both alone.
  always_comb begin
    data_d       = data_q;
    router_d     = router_q;
    edit_data    = sw_sel_data & ~sw_sel_router;
    edit_router  = sw_sel_router & ~sw_sel_data;
    one_key      = inc_rise ^ dec_rise;
    if (edit_data && one_key) begin
      data_d = inc_rise ? data_q + 1'b1 : data_q - 1'b1;
    end
    if (edit_router && one_key) begin
      if (inc_rise) begin
        router_d = (router_q == ROUTER_MAX) ? '0 : router_q + 1'b1;
      end else begin
        router_d = (router_q == '0) ? ROUTER_MAX : router_q - 1'b1;
      end
    end
    hex_data_d   = seg7(4'(data_q));
    hex_router_d = seg7(4'(router_q));
  end

  // Edit registers and the registered display glyphs (one cycle behind).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      router_q     <= '0;
      hex_data_q   <= SEG_ZERO;
      hex_router_q <= SEG_ZERO;
    end else begin
      data_q       <= data_d;
      router_q     <= router_d;
      hex_data_q   <= hex_data_d;
      hex_router_q <= hex_router_d;
    end
  end

  state_e            state_q, state_d;
  logic              bubble_q, bubble_d;
  logic [DATA_W-1:0] pkt_data_q, pkt_data_d;
  logic [IDX_W-1:0]  pkt_dst_q, pkt_dst_d;
  logic [15:0]       count_q, count_d;
  logic              presenting, accept;

  // Injection FSM: latch on send, hold the packet until accepted, then
  // either wait for key release (one-shot) or reload after a bubble.
  always_comb begin
    state_d    = state_q;
    bubble_d   = 1'b0;
    pkt_data_d = pkt_data_q;
    pkt_dst_d  = pkt_dst_q;
    count_d    = count_q;
    presenting = (state_q == ST_SEND) && !bubble_q;
    accept     = presenting && out_ready[pkt_dst_q];
    case (state_q)
      ST_IDLE: begin
        if (send_rise && sw_on) begin
          state_d    = ST_SEND;
          pkt_data_d = data_q;
          pkt_dst_d  = router_q;
        end
      end
      ST_SEND: begin
        if (accept) begin
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          if (!sw_on) begin
            state_d = ST_IDLE;
          end else if (!sw_mode) begin
            state_d = ST_HOLD;
          end else begin
            pkt_data_d = data_q;
            pkt_dst_d  = router_q;
            bubble_d   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!send_level) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, latched packet and acceptance counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bubble_q   <= 1'b0;
      pkt_data_q <= '0;
      pkt_dst_q  <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      bubble_q   <= bubble_d;
      pkt_data_q <= pkt_data_d;
      pkt_dst_q  <= pkt_dst_d;
      count_q    <= count_d;
    end
  end

  // One-hot valid and the shared data bus, zeroed when nothing is offered.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    if (presenting) begin
      out_valid[pkt_dst_q] = 1'b1;
      out_data             = {1'b1, pkt_data_q};
    end
  end

  assign pkt_count  = count_q;
  assign hex_data   = hex_data_q;
  assign hex_router = hex_router_q;
  assign dbg_state  = state_q;

endmodule
